// File: rtl/tone_arb_pkg.sv
// Shared types, constants and counter-width helpers for the tone arbiter.
package tone_arb_pkg;

    localparam int unsigned NUM_KEYS  = 4;
    localparam int unsigned KEY_IDX_W = 2;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_HALF_PERIOD_0   = 113600;
    localparam int unsigned DEF_HALF_PERIOD_1   = 101250;
    localparam int unsigned DEF_HALF_PERIOD_2   = 95550;
    localparam int unsigned DEF_HALF_PERIOD_3   = 85150;
    localparam int unsigned DEF_GAP_CYCLES      = 50000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Width of a counter running 0..terminal-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal < 2) ? 1 : $clog2(terminal);
    endfunction

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key input: 2-flop synchronizer followed by a stable-count debouncer.
module key_debounce
    import tone_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned DB_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept the synced level only after it has differed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DW'(DB_LAST)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/tone_arbiter.sv
// Four-key tone arbiter: debounce, pick a winner, sequence one shared square-wave generator.
// Optional macro TONE_ARB_LAST_NOTE_EN selects last-note priority instead of fixed low-index priority.
module tone_arbiter
    import tone_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HALF_PERIOD_0   = DEF_HALF_PERIOD_0,
    parameter int unsigned HALF_PERIOD_1   = DEF_HALF_PERIOD_1,
    parameter int unsigned HALF_PERIOD_2   = DEF_HALF_PERIOD_2,
    parameter int unsigned HALF_PERIOD_3   = DEF_HALF_PERIOD_3,
    parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_KEYS-1:0]  key,
    output logic                 speaker,
    output logic                 playing,
    output logic [KEY_IDX_W-1:0] active_key
);

    localparam int unsigned HP_MAX   = max_of4(HALF_PERIOD_0, HALF_PERIOD_1,
                                               HALF_PERIOD_2, HALF_PERIOD_3);
    localparam int unsigned TW       = cnt_width(HP_MAX);
    localparam int unsigned GW       = cnt_width(GAP_CYCLES);
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    logic [NUM_KEYS-1:0]  key_db;
    logic                 any_key_c;
    logic [KEY_IDX_W-1:0] winner_c;
    logic [TW-1:0]        hp_last_c;

    state_t               state;
    logic [TW-1:0]        tone_cnt;
    logic [GW-1:0]        gap_cnt;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (key[i]),
            .level (key_db[i])
        );
    end

    function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [KEY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_IDX_W'(i);
        end
        return idx;
    endfunction

    assign any_key_c = |key_db;

`ifdef TONE_ARB_LAST_NOTE_EN
    logic [NUM_KEYS-1:0]  key_db_q;
    logic [NUM_KEYS-1:0]  rises_c;
    logic [KEY_IDX_W-1:0] last_winner;

    // Newest press wins; on release of the winner fall back to the lowest key still held.
    always_comb begin
        rises_c = key_db & ~key_db_q;
        if (|rises_c) begin
            winner_c = lowest_set(rises_c);
        end else if (key_db[last_winner]) begin
            winner_c = last_winner;
        end else begin
            winner_c = lowest_set(key_db);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_db_q    <= '0;
            last_winner <= '0;
        end else begin
            key_db_q    <= key_db;
            last_winner <= winner_c;
        end
    end
`else
    assign winner_c = lowest_set(key_db);
`endif

    // Terminal tone count for the key currently sounding.
    always_comb begin
        case (active_key)
            2'd0:    hp_last_c = TW'(HALF_PERIOD_0 - 1);
            2'd1:    hp_last_c = TW'(HALF_PERIOD_1 - 1);
            2'd2:    hp_last_c = TW'(HALF_PERIOD_2 - 1);
            default: hp_last_c = TW'(HALF_PERIOD_3 - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            speaker    <= 1'b0;
            playing    <= 1'b0;
            active_key <= '0;
            tone_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (any_key_c) begin
                        state      <= PLAY;
                        playing    <= 1'b1;
                        active_key <= winner_c;
                        tone_cnt   <= '0;
                    end
                end

                // Release-all outranks a winner change; otherwise run the half-period counter.
                PLAY: begin
                    if (!any_key_c) begin
                        state   <= IDLE;
                        playing <= 1'b0;
                        speaker <= 1'b0;
                    end else if (winner_c != active_key) begin
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            playing <= 1'b0;
                            speaker <= 1'b0;
                            gap_cnt <= '0;
                        end else begin
                            active_key <= winner_c;
                            tone_cnt   <= '0;
                            speaker    <= 1'b0;
                        end
                    end else if (tone_cnt == hp_last_c) begin
                        speaker  <= ~speaker;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + TW'(1);
                    end
                end

                GAP: begin
                    speaker <= 1'b0;
                    if (gap_cnt == GW'(GAP_LAST)) begin
                        gap_cnt <= '0;
                        if (any_key_c) begin
                            state      <= PLAY;
                            playing    <= 1'b1;
                            active_key <= winner_c;
                            tone_cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    speaker <= 1'b0;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Randomized and directed bench for tone_arbiter against a behavioural model of key timing and note sequencing.
module tb_tone_arbiter;

    localparam int DB  = 4;
    localparam int GAP = 3;
    localparam int HP [4] = '{10, 9, 8, 7};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       speaker;
    logic       playing;
    logic [1:0] active_key;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    tone_arbiter #(
        .DEBOUNCE_CYCLES (DB),
        .HALF_PERIOD_0   (10),
        .HALF_PERIOD_1   (9),
        .HALF_PERIOD_2   (8),
        .HALF_PERIOD_3   (7),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .speaker    (speaker),
        .playing    (playing),
        .active_key (active_key)
    );

    always #5 clk = ~clk;

    // Model: raw key history, per-key "differing run", and note mode with time since note start.
    logic [3:0] m_s1, m_s2, m_db, m_dbq;
    int         m_run [4];
    int         m_last;
    int         m_mode;      // 0 silent, 1 sounding, 2 forced gap
    int         m_since;     // cycles since the current note started
    int         m_gap_left;
    int         m_act, m_spk, m_play;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int lowest_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int pick_winner();
`ifdef TONE_ARB_LAST_NOTE_EN
        logic [3:0] rises;
        rises = m_db & ~m_dbq;
        if (rises != 4'b0) return lowest_of(rises);
        if (m_db[m_last]) return m_last;
        return lowest_of(m_db);
`else
        return lowest_of(m_db);
`endif
    endfunction

    task automatic start_note(input int w);
        m_mode  = 1;
        m_play  = 1;
        m_act   = w;
        m_since = 0;
        m_spk   = 0;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] k);
        int w;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0; m_last = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_mode = 0; m_since = 0; m_gap_left = 0; m_act = 0; m_spk = 0; m_play = 0;
            return;
        end
        w = pick_winner();
        case (m_mode)
            0: begin
                m_spk = 0;
                if (m_db != 4'b0) start_note(w);
            end
            1: begin
                if (m_db == 4'b0) begin
                    m_mode = 0; m_spk = 0; m_play = 0;
                end else if (w != m_act) begin
                    m_mode = 2; m_gap_left = GAP; m_spk = 0; m_play = 0;
                end else begin
                    m_since++;
                    m_spk = (m_since / HP[m_act]) % 2;
                end
            end
            default: begin
                m_spk = 0;
                m_gap_left--;
                if (m_gap_left == 0) begin
                    if (m_db != 4'b0) start_note(w);
                    else m_mode = 0;
                end
            end
        endcase
        m_last = w;
        m_dbq  = m_db;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_db[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = k;
    endtask

    task automatic tick(input logic [3:0] k, input logic r);
        @(negedge clk);
        key   = k;
        reset = r;
        @(posedge clk);
        cyc++;
        model_step(r, k);
        #1;
        check_val("speaker", int'(speaker), m_spk);
        check_val("playing", int'(playing), m_play);
        check_val("active_key", int'(active_key), m_act);
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) tick(k, 1'b0);
    endtask

    logic [3:0] cur;

    initial begin
        key   = 4'b0;
        reset = 1'b1;

        tick(4'b0, 1'b1);
        tick(4'b0, 1'b1);
        check_val("reset_speaker", int'(speaker), 0);
        check_val("reset_playing", int'(playing), 0);

        // Single key: tone starts after debounce, 10-cycle half-period
        hold(4'b0001, 60);
        check_val("k0_playing", int'(playing), 1);
        hold(4'b0000, 12);

        // Short glitch never gets through
        hold(4'b0010, 3);
        hold(4'b0000, 12);
        check_val("glitch_playing", int'(playing), 0);

        // Simultaneous press resolves to key0
        hold(4'b0101, 40);
        check_val("simul_active", int'(active_key), 0);
        hold(4'b0000, 12);

        // Winner change through the gap
        hold(4'b0100, 30);
        hold(4'b0101, 40);
        hold(4'b0000, 12);
        hold(4'b0001, 30);
        hold(4'b1001, 30);
        hold(4'b0001, 30);

        // Release all in the middle of a high half-period
        for (int i = 0; i < 40 && m_spk == 0; i++) tick(4'b0001, 1'b0);
        hold(4'b0001, 3);
        check_val("mid_high_speaker", int'(speaker), 1);
        hold(4'b0000, 12);
        check_val("release_playing", int'(playing), 0);

        // Reset while sounding high, key kept held afterwards
        hold(4'b0001, 8);
        for (int i = 0; i < 40 && m_spk == 0; i++) tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b1);
        check_val("rst_mid_speaker", int'(speaker), 0);
        check_val("rst_mid_playing", int'(playing), 0);
        hold(4'b0001, 30);
        hold(4'b0000, 12);

        // Random key patterns, glitches and resets
        cur = 4'b0;
        for (int s = 0; s < 400; s++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                tick(cur, 1'b1);
            end else if (r < 18) begin
                hold(4'($urandom_range(0, 15)), $urandom_range(1, 3));
                hold(cur, $urandom_range(1, 5));
            end else begin
                cur = 4'($urandom_range(0, 15));
                hold(cur, $urandom_range(1, 35));
            end
        end
        hold(4'b0000, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
